// File: rtl/mem_pkg.sv
// Definitions shared between the SRAM core stage and its request front end:
// control codes, sequencer state encoding and datapath widths.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'b00,
        CTRL_WRITE = 2'b01,
        CTRL_READ  = 2'b10
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    // A phase lasting N cycles is timed by loading N-1 and counting to zero.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one sequencer phase; done is high at zero.
module phase_timer
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_sequencer.sv
// Front end for the SRAM core: accepts one request at a time and plays it out
// as a registered SETUP / STROBE / HOLD sequence on control, addr and dataWrite.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        control,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataWrite,
    input  logic [DATA_W-1:0] dataRead,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high exactly while in IDLE, and the
    // master holds req_* stable until that edge.

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

    state_t           state;
    ctrl_t            ctrl_q;
    logic             wr_q;
    logic             tm_load;
    logic             tm_dec;
    logic [CNT_W-1:0] tm_val;
    logic [CNT_W-1:0] cnt;
    logic             done;

    phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tm_load),
        .dec      (tm_dec),
        .load_val (tm_val),
        .cnt      (cnt),
        .done     (done)
    );

    always_comb begin
        tm_load = 1'b0;
        tm_dec  = 1'b0;
        tm_val  = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    tm_load = 1'b1;
                    tm_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (done) begin
                    tm_load = 1'b1;
                    tm_val  = STROBE_LD;
                end else begin
                    tm_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (done) begin
                    tm_load = 1'b1;
                    tm_val  = HOLD_LD;
                end else begin
                    tm_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                tm_dec = !done;
            end
            default: begin
                tm_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ctrl_q     <= CTRL_IDLE;
            wr_q       <= 1'b0;
            addr       <= '0;
            dataWrite  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr      <= req_addr;
                        dataWrite <= req_wdata;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Strobe code is registered here so it is stable for the
                    // whole first STROBE cycle.
                    if (done) begin
                        ctrl_q <= wr_q ? CTRL_WRITE : CTRL_READ;
                        state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (done) begin
                        if (!wr_q) begin
                            resp_rdata <= dataRead;
                        end
                        ctrl_q <= CTRL_IDLE;
                        state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (done) begin
                        resp_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign control   = ctrl_q;
    assign dbg_state = state;

endmodule
